interpol_4x: RTL and testbench



---
 rtl/interpol_4x_pkg.sv | 11 +
 rtl/interpol_4x.sv | 62 ++++++
 tb/tb_interpol_4x.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/interpol_4x_pkg.sv
// Shared constants and types for the 4x linear interpolator.
package interpol_4x_pkg;

  localparam int DEFAULT_DATA_WIDTH = 18;
  localparam int PHASE_COUNT        = 4;

  typedef logic [1:0] phase_t;

  localparam phase_t PHASE_LAST = phase_t'(PHASE_COUNT - 1);

endpackage

// File: rtl/interpol_4x.sv
// Linear 4x interpolator: one sample in per clkenin, four weighted blends of
// the last two samples out per input period on clken4x.
module interpol_4x
  import interpol_4x_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clkenin,
  input  logic                         clken4x,
  input  logic signed [DATA_WIDTH-1:0] xkin,
  output logic signed [DATA_WIDTH-1:0] ykout
);

  localparam int SUM_WIDTH = DATA_WIDTH + 2;

  logic signed [DATA_WIDTH-1:0] samplea;
  logic signed [DATA_WIDTH-1:0] sampleb;
  phase_t                       phase;

  logic signed [SUM_WIDTH-1:0] aext;
  logic signed [SUM_WIDTH-1:0] bext;
  logic signed [SUM_WIDTH-1:0] weighted;

  assign aext = SUM_WIDTH'(samplea);
  assign bext = SUM_WIDTH'(sampleb);

  // (4-P)*A + P*B built from shifts and adds; two guard bits keep it exact.
  always_comb begin
    weighted = aext <<< 2;
    case (phase)
      2'd1:    weighted = (aext <<< 1) + aext + bext;
      2'd2:    weighted = (aext + bext) <<< 1;
      2'd3:    weighted = aext + (bext <<< 1) + bext;
      default: weighted = aext <<< 2;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      samplea <= '0;
      sampleb <= '0;
      phase   <= '0;
      ykout   <= '0;
    end else if (clkenin) begin
      samplea <= sampleb;
      sampleb <= xkin;
      phase   <= phase_t'(1);
      if (clken4x) begin
        ykout <= sampleb;
      end
    end else if (clken4x) begin
      // Dropping the two low bits is the floor-toward-minus-infinity divide by 4.
      ykout <= weighted[SUM_WIDTH-1:2];
      if (phase != PHASE_LAST) begin
        phase <= phase_t'(phase + 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_interpol_4x.sv
// Directed self-checking bench for interpol_4x with hand-computed expectations.
module tb_interpol_4x;

  logic               clock;
  logic               reset;
  logic               clkenin;
  logic               clken4x;
  logic signed [17:0] xkin;
  logic signed [17:0] ykout;

  int vectors;
  int miscompares;

  interpol_4x #(.DATA_WIDTH(18)) dut (
    .clock   (clock),
    .reset   (reset),
    .clkenin (clkenin),
    .clken4x (clken4x),
    .xkin    (xkin),
    .ykout   (ykout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One enable edge followed by idle clocks; leaves time just past a rising edge.
  task automatic pulse(input logic en_in, input logic en_4x, input int x);
    @(negedge clock);
    clkenin = en_in;
    clken4x = en_4x;
    xkin    = 18'(x);
    @(posedge clock);
    #1;
    clkenin = 1'b0;
    clken4x = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pulse(i % 4 == 0, 1'b1, 5000);
      vectors++;
      if (ykout !== 18'sd0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold[%0d]: got %0d expected 0", i, ykout);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    pulse(1'b1, 1'b1, 5000);
    vectors++;
    if (ykout !== 18'sd0) begin
      miscompares++;
      $display("[TB] FAIL reset_first: got %0d expected 0", ykout);
    end
    pulse(1'b0, 1'b1, 0);
    vectors++;
    if (ykout !== 18'sd1250) begin
      miscompares++;
      $display("[TB] FAIL reset_phase1: got %0d expected 1250", ykout);
    end
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      pulse(i % 4 == 0, 1'b1, 1000);
      if (i >= 4) begin
        vectors++;
        if (ykout !== 18'sd1000) begin
          miscompares++;
          $display("[TB] FAIL constant[%0d]: got %0d expected 1000", i, ykout);
        end
      end
    end
  endtask

  task automatic test_ramp();
    int expv[8] = '{0, 100, 200, 300, 400, 500, 600, 700};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pulse(i % 4 == 0, 1'b1, (i == 0) ? 400 : 800);
      vectors++;
      if (ykout !== 18'(expv[i])) begin
        miscompares++;
        $display("[TB] FAIL ramp[%0d]: got %0d expected %0d", i, ykout, expv[i]);
      end
    end
  endtask

  task automatic test_negative_floor();
    int expv[4] = '{0, -1, -2, -3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse(i == 0, 1'b1, -3);
      vectors++;
      if (ykout !== 18'(expv[i])) begin
        miscompares++;
        $display("[TB] FAIL negfloor[%0d]: got %0d expected %0d", i, ykout, expv[i]);
      end
    end
  endtask

  task automatic test_extremes();
    int expv[4] = '{131071, 65535, -1, -65537};
    do_reset();
    pulse(1'b1, 1'b1, 131071);
    for (int i = 0; i < 4; i++) begin
      pulse(i == 0, 1'b1, -131072);
      vectors++;
      if (ykout !== 18'(expv[i])) begin
        miscompares++;
        $display("[TB] FAIL extremes[%0d]: got %0d expected %0d", i, ykout, expv[i]);
      end
    end
  endtask

  task automatic test_enable_skew();
    int expv[5] = '{800, 600, 400, 200, 200};
    do_reset();
    pulse(1'b1, 1'b1, 400);
    pulse(1'b0, 1'b1, 0);
    pulse(1'b1, 1'b0, 800);
    vectors++;
    if (ykout !== 18'sd100) begin
      miscompares++;
      $display("[TB] FAIL skew_hold: got %0d expected 100", ykout);
    end
    pulse(1'b0, 1'b1, 0);
    vectors++;
    if (ykout !== 18'sd500) begin
      miscompares++;
      $display("[TB] FAIL skew_phase1: got %0d expected 500", ykout);
    end
    pulse(1'b0, 1'b1, 0);
    pulse(1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      pulse(i == 0, 1'b1, 0);
      vectors++;
      if (ykout !== 18'(expv[i])) begin
        miscompares++;
        $display("[TB] FAIL saturate[%0d]: got %0d expected %0d", i, ykout, expv[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse(1'b1, 1'b1, 400);
    pulse(1'b1, 1'b1, 800);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (ykout !== 18'sd0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %0d expected 0", ykout);
    end
    @(negedge clock);
    reset = 1'b1;
    pulse(1'b1, 1'b1, 400);
    vectors++;
    if (ykout !== 18'sd0) begin
      miscompares++;
      $display("[TB] FAIL reset_restart0: got %0d expected 0", ykout);
    end
    pulse(1'b0, 1'b1, 0);
    vectors++;
    if (ykout !== 18'sd100) begin
      miscompares++;
      $display("[TB] FAIL reset_restart1: got %0d expected 100", ykout);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    clkenin     = 1'b0;
    clken4x     = 1'b0;
    xkin        = '0;
    test_reset();
    test_constant();
    test_ramp();
    test_negative_floor();
    test_extremes();
    test_enable_skew();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
